// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLoad,
        StShift,
        StCommit
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for an asynchronous pin, with optional rise/fall pulses
// taken from one extra flop after the last stage.
module spi_sync
    import spi_pkg::*;
#(
    parameter int unsigned STAGES      = SYNC_STAGES,
    parameter logic        RESET_VAL   = 1'b0,
    parameter bit          EDGE_DETECT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

    if (EDGE_DETECT) begin : g_edge
        logic prev_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q <= RESET_VAL;
            end else begin
                prev_q <= sync_q[STAGES-1];
            end
        end

        assign rise_o = sync_q[STAGES-1] & ~prev_q;
        assign fall_o = ~sync_q[STAGES-1] & prev_q;
    end else begin : g_no_edge
        assign rise_o = 1'b0;
        assign fall_o = 1'b0;
    end

endmodule

// File: rtl/spi_slave_driver.sv
// Mode-0 SPI slave: swaps one host word for one buffered word per transfer and
// reports frame completion, abort and overflow.
module spi_slave_driver
    import spi_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned BUF_SIZE   = 10,
    localparam int unsigned CNT_W      = cnt_width(BUF_SIZE),
    localparam int unsigned BIT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    output logic                  miso,
    output logic                  buf_rst,
    output logic                  buf_wr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    input  logic [DATA_WIDTH-1:0] buf_rdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  overflow,
    output logic [CNT_W-1:0]      word_cnt
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync #(.RESET_VAL(1'b0), .EDGE_DETECT(1'b1)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sclk),
        .q_o    (unused_sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // cs_n idles high, so reset the chain high to avoid a false frame start.
    spi_sync #(.RESET_VAL(1'b1), .EDGE_DETECT(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cs_n),
        .q_o    (unused_cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync #(.RESET_VAL(1'b0), .EDGE_DETECT(1'b0)) u_mosi_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (mosi),
        .q_o    (mosi_s),
        .rise_o (unused_mosi_rise),
        .fall_o (unused_mosi_fall)
    );

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic                  miso_q, miso_d, overflow_q, overflow_d;
    logic                  done_q, done_d, abort_q, abort_d;
    logic                  buf_full;

    assign buf_full = (word_cnt_q == CNT_W'(BUF_SIZE));

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        miso_d     = miso_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        buf_rst    = 1'b0;
        buf_wr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    word_cnt_d = '0;
                    overflow_d = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                buf_rst   = 1'b1;
                bit_cnt_d = '0;
                state_d   = StLoad;
            end
            StLoad: begin
                // Once the buffer is full the master only gets zeros back.
                tx_shift_d = buf_full ? '0 : buf_rdata;
                miso_d     = buf_full ? 1'b0 : buf_rdata[DATA_WIDTH-1];
                bit_cnt_d  = '0;
                state_d    = StShift;
            end
            StShift: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StCommit;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall && bit_cnt_q != '0) begin
                    // The trailing fall of the previous word must not consume the new MSB.
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    miso_d     = tx_shift_q[DATA_WIDTH-2];
                end
            end
            StCommit: begin
                state_d = StLoad;
                if (!buf_full) begin
                    buf_wr     = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (cs_rise && state_q != StIdle) begin
            state_d    = StIdle;
            buf_wr     = 1'b0;
            word_cnt_d = word_cnt_q;
            overflow_d = overflow_q;
            miso_d     = 1'b0;
            if (bit_cnt_q == '0 && (state_q == StShift || state_q == StLoad)) begin
                done_d = 1'b1;
            end else begin
                abort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            miso_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            miso_q     <= miso_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign miso        = miso_q;
    assign buf_wdata   = rx_shift_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign overflow    = overflow_q;
    assign word_cnt    = word_cnt_q;

endmodule
